fifo_registradores: RTL and testbench

FIFO_REGISTRADORES -- requirements
Module: fifo_registradores

---
 rtl/fifo_registradores_pkg.sv | 23 ++
 rtl/fifo_registradores_registrador.sv | 32 +++
 rtl/fifo_registradores.sv | 101 ++++++++++
 tb/tb_fifo_registradores.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fifo_registradores_pkg.sv
// ============================================================================
// fifo_registradores_pkg
// Classification of the operation the FIFO actually performs in a cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_registradores_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e classify_op(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({push_ok, pop_ok});
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_registradores_registrador.sv
// ============================================================================
// registrador_sincrono
// N-bit storage word with synchronous clear and write enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module registrador_sincrono #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] data_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

`default_nettype wire

// File: rtl/fifo_registradores.sv
// ============================================================================
// fifo_registradores
// First-word-fall-through register FIFO with count and sticky error flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_registradores
  import fifo_registradores_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [N-1:0]           D,
  output logic [N-1:0]           Q,
  output logic                   vazio,
  output logic                   cheio,
  output logic [$clog2(DEPTH):0] contagem,
  output logic                   erro
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          erro_q,   erro_d;

  logic          w_push_ok;
  logic          w_pop_ok;
  logic [N-1:0]  w_mem [DEPTH];

  assign vazio = (count_q == '0);
  assign cheio = (count_q == CW'(DEPTH));

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_push_ok = push & (~cheio | pop);
  assign w_pop_ok  = pop & ~vazio;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    erro_d   = erro_q | (push & cheio & ~pop) | (pop & vazio & ~push);
    case (classify_op(w_push_ok, w_pop_ok))
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CW'(1);
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_q - CW'(1);
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      erro_q   <= erro_d;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      registrador_sincrono #(
        .N(N)
      ) u_word (
        .clock(clock),
        .clear(clear),
        .en   (w_push_ok && (wr_ptr_q == PW'(i))),
        .d    (D),
        .q    (w_mem[i])
      );
    end
  endgenerate

  assign Q        = vazio ? '0 : w_mem[rd_ptr_q];
  assign contagem = count_q;
  assign erro     = erro_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_registradores.sv
// ============================================================================
// tb_fifo_registradores
// Directed and random traffic against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_registradores;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          push  = 1'b0;
  logic          pop   = 1'b0;
  logic [N-1:0]  D     = '0;
  logic [N-1:0]  Q;
  logic          vazio;
  logic          cheio;
  logic [CW-1:0] contagem;
  logic          erro;

  int tests = 0;
  int fails = 0;

  int unsigned mq[$];
  logic        erro_m = 1'b0;

  fifo_registradores #(
    .N    (N),
    .DEPTH(DEPTH)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .D       (D),
    .Q       (Q),
    .vazio   (vazio),
    .cheio   (cheio),
    .contagem(contagem),
    .erro    (erro)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic c, input logic p, input logic o, input logic [N-1:0] d);
    logic full, empty;
    clear = c; push = p; pop = o; D = d;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (c) begin
      mq.delete();
      erro_m = 1'b0;
    end else begin
      if ((p && full && !o) || (o && empty && !p)) erro_m = 1'b1;
      if (o && !empty) void'(mq.pop_front());
      if (p && (!full || o)) mq.push_back(int'(d));
    end
    @(posedge clock);
    #1;
    clear = 1'b0; push = 1'b0; pop = 1'b0;
    check("Q",        Q,        (mq.size() != 0) ? mq[0] : 0);
    check("vazio",    vazio,    (mq.size() == 0) ? 1 : 0);
    check("cheio",    cheio,    (mq.size() == DEPTH) ? 1 : 0);
    check("contagem", contagem, mq.size());
    check("erro",     erro,     erro_m);
  endtask

  initial begin
    int pp;
    int op;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0);
    check("rst_vazio", vazio, 1);
    check("rst_Q", Q, 0);

    // Fill and drain
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, N'(i));
    check("fill_cheio", cheio, 1);
    check("fill_cnt", contagem, 8);
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_Q", Q, i);
      step(1'b0, 1'b0, 1'b1, '0);
    end
    check("drain_vazio", vazio, 1);
    check("drain_Q0", Q, 0);

    // Overflow: 9 must be dropped
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, N'(i));
    step(1'b0, 1'b1, 1'b0, N'(9));
    check("ovf_erro", erro, 1);
    check("ovf_cnt", contagem, 8);
    for (int i = 1; i <= DEPTH; i++) begin
      check("ovf_Q", Q, i);
      step(1'b0, 1'b0, 1'b1, '0);
    end

    // Underflow
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("unf_erro", erro, 1);
    check("unf_vazio", vazio, 1);
    step(1'b0, 1'b1, 1'b0, N'(5));
    check("unf_Q", Q, 5);
    check("unf_sticky", erro, 1);

    // Simultaneous push/pop when full, then when empty
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, N'(i));
    step(1'b0, 1'b1, 1'b1, N'(10));
    check("sim_full_cnt", contagem, 8);
    check("sim_full_Q", Q, 2);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 1'b1, '0);
    check("sim_last_A", Q, 10);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, N'(3));
    check("sim_empty_cnt", contagem, 1);
    check("sim_empty_Q", Q, 3);
    check("sim_empty_erro", erro, 0);

    // Wrap-around with alternating push/pop
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        step(1'b0, 1'b1, 1'b0, N'(i / 2));
        check("wrap_Q", Q, i / 2);
      end else begin
        step(1'b0, 1'b0, 1'b1, '0);
      end
      check("wrap_cnt_le1", (contagem <= 1) ? 1 : 0, 1);
    end

    // Clear in the middle of traffic, starting with erro set
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, N'($urandom_range(0, 15)));
    step(1'b1, 1'b1, 1'b0, N'(7));
    check("clr_cnt", contagem, 0);
    check("clr_vazio", vazio, 1);
    check("clr_Q", Q, 0);
    check("clr_erro", erro, 0);

    // Random traffic with shifting push bias and occasional clears
    for (int seg = 0; seg < 3; seg++) begin
      pp = (seg == 0) ? 70 : (seg == 1) ? 30 : 50;
      for (int k = 0; k < 150; k++) begin
        op = int'($urandom_range(0, 99));
        step(($urandom_range(0, 63) == 0),
             (op < pp),
             ($urandom_range(0, 99) >= pp),
             N'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
